// File: rtl/branch_resolution_unit_pkg.sv
// Shared types for the branch resolution unit: tracker record, FSM states, instruction size.
package branch_resolution_unit_pkg;

  localparam int INSTR_BYTES = 4;
  // Tracker records are sized for the default 32-bit PC; ADDR_WIDTH is expected to match.
  localparam int BRU_ADDR_W  = 32;

  typedef struct packed {
    logic                  valid;
    logic                  pred;
    logic [BRU_ADDR_W-1:0] pc;
    logic [BRU_ADDR_W-1:0] target;
  } branch_track_t;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } bru_state_e;

endpackage

// File: rtl/branch_resolution_unit_if.sv
// Branch-prediction / pipeline-control bundle between the core pipeline and the resolution unit.
interface branch_resolution_unit_if #(
  parameter int ADDR_WIDTH = 32
);

  logic                  id_branch_valid;
  logic                  id_prediction;
  logic [ADDR_WIDTH-1:0] id_pc;
  logic [ADDR_WIDTH-1:0] id_target;
  logic                  pipe_stall;
  logic                  mem_actual_taken;
  logic                  upd_valid;
  logic [ADDR_WIDTH-1:0] upd_pc;
  logic                  upd_taken;
  logic                  flush;
  logic [ADDR_WIDTH-1:0] redirect_pc;

  modport master (
    output id_branch_valid, id_prediction, id_pc, id_target, pipe_stall, mem_actual_taken,
    input  upd_valid, upd_pc, upd_taken, flush, redirect_pc
  );

  modport slave (
    input  id_branch_valid, id_prediction, id_pc, id_target, pipe_stall, mem_actual_taken,
    output upd_valid, upd_pc, upd_taken, flush, redirect_pc
  );

endinterface

// File: rtl/branch_resolution_unit_sat_counter.sv
// Saturating up-counter used for the branch statistics; sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/branch_resolution_unit.sv
// Tracks predicted branches from decode to MEM, trains the predictor and redirects fetch on mispredict.
module branch_resolution_unit
  import branch_resolution_unit_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int TRACK_DEPTH = 2,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  branch_resolution_unit_if.slave bus,
  output logic [COUNT_WIDTH-1:0] branch_count,
  output logic [COUNT_WIDTH-1:0] mispredict_count
);

  localparam logic [0:0] ST_IDLE     = 1'(IDLE);
  localparam logic [0:0] ST_REDIRECT = 1'(REDIRECT);

  branch_track_t track [TRACK_DEPTH];
  branch_track_t last;
  logic          resolve;
  logic          mispredict;
  logic [0:0]    state;

  function automatic logic [ADDR_WIDTH-1:0] next_pc(input logic [ADDR_WIDTH-1:0] pc,
                                                    input logic [ADDR_WIDTH-1:0] target,
                                                    input logic                  taken);
    return taken ? target : pc + ADDR_WIDTH'(INSTR_BYTES);
  endfunction

  assign last       = track[TRACK_DEPTH-1];
  assign resolve    = last.valid & ~bus.pipe_stall;
  assign mispredict = resolve & (last.pred ^ bus.mem_actual_taken);

  // Tracker: ID capture into slot 0, shift toward MEM; a mispredict kills every younger entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < TRACK_DEPTH; k++) track[k] <= '0;
    end else if (!bus.pipe_stall) begin
      track[0].valid  <= bus.id_branch_valid & ~mispredict;
      track[0].pred   <= bus.id_prediction;
      track[0].pc     <= bus.id_pc;
      track[0].target <= bus.id_target;
      for (int k = 1; k < TRACK_DEPTH; k++) begin
        track[k]       <= track[k-1];
        track[k].valid <= track[k-1].valid & ~mispredict;
      end
    end
  end

  // MEM resolve: registered training strobe, redirect target and flush FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      bus.upd_valid   <= 1'b0;
      bus.upd_pc      <= '0;
      bus.upd_taken   <= 1'b0;
      bus.redirect_pc <= '0;
    end else begin
      case (state)
        ST_IDLE: if (mispredict) state <= ST_REDIRECT;
        default: state <= ST_IDLE;
      endcase
      bus.upd_valid <= resolve;
      if (resolve) begin
        bus.upd_pc    <= last.pc;
        bus.upd_taken <= bus.mem_actual_taken;
      end
      if (mispredict) begin
        bus.redirect_pc <= next_pc(last.pc, last.target, bus.mem_actual_taken);
      end
    end
  end

  assign bus.flush = (state == ST_REDIRECT);

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_branch_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (1'b0),
    .inc     (resolve),
    .count   (branch_count)
  );

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_mispredict_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (1'b0),
    .inc     (mispredict),
    .count   (mispredict_count)
  );

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Self-checking bench for branch_resolution_unit: directed table, corner sequences, random vs. model.
module tb_branch_resolution_unit;

  localparam int AW    = 32;
  localparam int DEPTH = 2;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [CW-1:0] branch_count;
  logic [CW-1:0] mispredict_count;
  int errors = 0;
  int checks = 0;

  branch_resolution_unit_if #(.ADDR_WIDTH(AW)) bus ();

  branch_resolution_unit #(
    .ADDR_WIDTH  (AW),
    .TRACK_DEPTH (DEPTH),
    .COUNT_WIDTH (CW)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .bus              (bus),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] target;
    logic        pred;
    logic        actual;
    logic        exp_flush;
    logic [31:0] exp_redirect;
  } vec_t;

  typedef struct {
    logic        pred;
    logic [31:0] pc;
    logic [31:0] target;
    int          rem;
  } inflight_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic p, input logic [31:0] pc, input logic [31:0] tg);
    bus.id_branch_valid = v;
    bus.id_prediction   = p;
    bus.id_pc           = pc;
    bus.id_target       = tg;
  endtask

  function automatic int sat(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  vec_t        vecs [5];
  int          exp_b, exp_m;
  logic [2:0]  preds;
  inflight_t   q[$];
  inflight_t   e;
  logic        m_uv, m_fl, m_taken, res, mis;
  logic [31:0] m_pc, m_redirect;
  int          m_b, m_m;
  logic        r_v, r_p, r_s, r_a;
  logic [31:0] r_pc, r_tg;

  initial begin
    set_id(1'b0, 1'b0, '0, '0);
    bus.pipe_stall       = 1'b0;
    bus.mem_actual_taken = 1'b0;
    step();
    step();
    chk("reset_upd_valid", 32'(bus.upd_valid), 0);
    chk("reset_flush", 32'(bus.flush), 0);
    chk("reset_upd_taken", 32'(bus.upd_taken), 0);
    chk("reset_upd_pc", bus.upd_pc, 0);
    chk("reset_redirect", bus.redirect_pc, 0);
    chk("reset_bcnt", 32'(branch_count), 0);
    chk("reset_mcnt", 32'(mispredict_count), 0);
    reset_n = 1'b1;

    // ---------------- directed table ----------------
    vecs[0] = '{32'h0000_0100, 32'h0000_0140, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[1] = '{32'h0000_0200, 32'h0000_0180, 1'b1, 1'b0, 1'b1, 32'h0000_0204};
    vecs[2] = '{32'hFFFF_FFFC, 32'h0000_0010, 1'b0, 1'b1, 1'b1, 32'h0000_0010};
    vecs[3] = '{32'hFFFF_FFFC, 32'h0000_0010, 1'b1, 1'b0, 1'b1, 32'h0000_0000};
    vecs[4] = '{32'h0000_0600, 32'h0000_0640, 1'b0, 1'b0, 1'b0, 32'h0};
    exp_b = 0;
    exp_m = 0;
    for (int i = 0; i < 5; i++) begin
      set_id(1'b1, vecs[i].pred, vecs[i].pc, vecs[i].target);
      step();
      set_id(1'b0, 1'b0, '0, '0);
      step();
      chk("tbl_early_upd", 32'(bus.upd_valid), 0);
      bus.mem_actual_taken = vecs[i].actual;
      // a decoy branch in decode on a mispredict resolve edge must be discarded
      if (vecs[i].exp_flush) set_id(1'b1, 1'b0, 32'hDEAD_0000, 32'hDEAD_0040);
      step();
      exp_b = sat(exp_b + 1);
      if (vecs[i].exp_flush) exp_m = sat(exp_m + 1);
      chk("tbl_upd_valid", 32'(bus.upd_valid), 1);
      chk("tbl_upd_pc", bus.upd_pc, vecs[i].pc);
      chk("tbl_upd_taken", 32'(bus.upd_taken), 32'(vecs[i].actual));
      chk("tbl_flush", 32'(bus.flush), 32'(vecs[i].exp_flush));
      if (vecs[i].exp_flush) chk("tbl_redirect", bus.redirect_pc, vecs[i].exp_redirect);
      chk("tbl_bcnt", 32'(branch_count), 32'(exp_b));
      chk("tbl_mcnt", 32'(mispredict_count), 32'(exp_m));
      set_id(1'b0, 1'b0, '0, '0);
      bus.mem_actual_taken = 1'b0;
      step();
      chk("tbl_pulse_end", 32'(bus.upd_valid), 0);
      chk("tbl_flush_end", 32'(bus.flush), 0);
      step();
      chk("tbl_decoy_dropped", 32'(bus.upd_valid), 0);
    end

    // ---------------- stall while entry waits in MEM ----------------
    set_id(1'b1, 1'b0, 32'h0000_0300, 32'h0000_0380);
    step();
    set_id(1'b0, 1'b0, '0, '0);
    step();
    bus.pipe_stall       = 1'b1;
    bus.mem_actual_taken = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("stall_no_upd", 32'(bus.upd_valid), 0);
      chk("stall_no_flush", 32'(bus.flush), 0);
    end
    bus.pipe_stall       = 1'b0;
    bus.mem_actual_taken = 1'b0;
    step();
    exp_b = sat(exp_b + 1);
    chk("stall_release_upd", 32'(bus.upd_valid), 1);
    chk("stall_release_pc", bus.upd_pc, 32'h0000_0300);
    chk("stall_release_flush", 32'(bus.flush), 0);
    chk("stall_bcnt", 32'(branch_count), 32'(exp_b));
    step();
    chk("stall_single_pulse", 32'(bus.upd_valid), 0);
    chk("stall_bcnt_once", 32'(branch_count), 32'(exp_b));

    // ---------------- mispredict followed by stall during REDIRECT ----------------
    set_id(1'b1, 1'b1, 32'h0000_0400, 32'h0000_0480);
    step();
    set_id(1'b0, 1'b0, '0, '0);
    step();
    bus.mem_actual_taken = 1'b0;
    step();
    exp_b = sat(exp_b + 1);
    exp_m = sat(exp_m + 1);
    chk("redir_flush", 32'(bus.flush), 1);
    chk("redir_pc", bus.redirect_pc, 32'h0000_0404);
    bus.pipe_stall = 1'b1;
    step();
    chk("redir_stall_flush_1cyc", 32'(bus.flush), 0);
    step();
    chk("redir_stall_flush_low", 32'(bus.flush), 0);
    chk("redir_stall_no_upd", 32'(bus.upd_valid), 0);
    bus.pipe_stall = 1'b0;
    chk("redir_mcnt", 32'(mispredict_count), 32'(exp_m));

    // ---------------- back-to-back branches ----------------
    preds = 3'b101;
    for (int c = 0; c < 5; c++) begin
      if (c < 3) set_id(1'b1, preds[c], 32'h0000_0500 + 32'(4 * c), 32'h0000_0900);
      else       set_id(1'b0, 1'b0, '0, '0);
      bus.mem_actual_taken = (c >= 2) ? preds[c-2] : 1'b0;
      step();
      if (c >= 2) begin
        exp_b = sat(exp_b + 1);
        chk("b2b_upd_valid", 32'(bus.upd_valid), 1);
        chk("b2b_upd_pc", bus.upd_pc, 32'h0000_0500 + 32'(4 * (c - 2)));
        chk("b2b_upd_taken", 32'(bus.upd_taken), 32'(preds[c-2]));
        chk("b2b_flush", 32'(bus.flush), 0);
      end
    end
    step();
    chk("b2b_end", 32'(bus.upd_valid), 0);
    chk("b2b_bcnt", 32'(branch_count), 32'(exp_b));

    // ---------------- saturation then async reset with two slots in flight ----------------
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    bus.mem_actual_taken = 1'b1;
    for (int c = 0; c < 19; c++) begin
      if (c < 17) set_id(1'b1, 1'b1, 32'h0000_1000 + 32'(4 * c), 32'h0000_2000);
      else        set_id(1'b0, 1'b0, '0, '0);
      step();
    end
    chk("sat_bcnt", 32'(branch_count), 32'hF);
    chk("sat_mcnt", 32'(mispredict_count), 0);
    set_id(1'b1, 1'b0, 32'h0000_0700, 32'h0000_0780);
    step();
    set_id(1'b1, 1'b0, 32'h0000_0704, 32'h0000_0784);
    step();
    set_id(1'b0, 1'b0, '0, '0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_bcnt", 32'(branch_count), 0);
    chk("arst_mcnt", 32'(mispredict_count), 0);
    chk("arst_upd_valid", 32'(bus.upd_valid), 0);
    chk("arst_flush", 32'(bus.flush), 0);
    step();
    step();
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("arst_dropped_no_upd", 32'(bus.upd_valid), 0);
    end
    chk("arst_bcnt_stays", 32'(branch_count), 0);

    // ---------------- async reset clears an active flush ----------------
    set_id(1'b1, 1'b1, 32'h0000_0800, 32'h0000_0840);
    step();
    set_id(1'b0, 1'b0, '0, '0);
    step();
    bus.mem_actual_taken = 1'b0;
    step();
    chk("arst2_flush_before", 32'(bus.flush), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst2_flush", 32'(bus.flush), 0);
    chk("arst2_redirect", bus.redirect_pc, 0);
    chk("arst2_mcnt", 32'(mispredict_count), 0);
    step();
    reset_n = 1'b1;

    // ---------------- randomized run against countdown model ----------------
    q.delete();
    m_uv = 0; m_fl = 0; m_taken = 0; m_pc = '0; m_redirect = '0; m_b = 0; m_m = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc % 100 == 99) begin
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        q.delete();
        m_uv = 0; m_fl = 0; m_taken = 0; m_pc = '0; m_redirect = '0; m_b = 0; m_m = 0;
        continue;
      end
      r_v  = ($urandom_range(0, 99) < 60);
      r_p  = 1'($urandom);
      r_pc = $urandom & 32'hFFFF_FFFC;
      r_tg = $urandom & 32'hFFFF_FFFC;
      r_s  = ($urandom_range(0, 99) < 25);
      r_a  = 1'($urandom);
      set_id(r_v, r_p, r_pc, r_tg);
      bus.pipe_stall       = r_s;
      bus.mem_actual_taken = r_a;
      m_uv = 0;
      m_fl = 0;
      if (!r_s) begin
        res = (q.size() > 0) && (q[0].rem == 0);
        mis = 1'b0;
        if (res) begin
          e = q.pop_front();
          m_uv    = 1;
          m_pc    = e.pc;
          m_taken = r_a;
          m_b     = sat(m_b + 1);
          if (e.pred != r_a) begin
            mis        = 1'b1;
            m_fl       = 1;
            m_m        = sat(m_m + 1);
            m_redirect = r_a ? e.target : e.pc + 32'd4;
          end
        end
        if (mis) q.delete();
        else begin
          foreach (q[i]) q[i].rem--;
          if (r_v) q.push_back('{r_p, r_pc, r_tg, DEPTH - 1});
        end
      end
      step();
      chk("rnd_upd_valid", 32'(bus.upd_valid), 32'(m_uv));
      chk("rnd_flush", 32'(bus.flush), 32'(m_fl));
      if (m_uv) begin
        chk("rnd_upd_pc", bus.upd_pc, m_pc);
        chk("rnd_upd_taken", 32'(bus.upd_taken), 32'(m_taken));
      end
      if (m_fl) chk("rnd_redirect", bus.redirect_pc, m_redirect);
      chk("rnd_bcnt", 32'(branch_count), 32'(m_b));
      chk("rnd_mcnt", 32'(mispredict_count), 32'(m_m));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
